// File: rtl/interp_pkg.sv
// interp_pkg: phase encoding, s-tag layout and sel boundary constants shared by the
// sel sequencer, input_array_mux users and the filter.
package interp_pkg;

    localparam int unsigned NUM_PIXEL_DEF = 8;
    localparam int unsigned SEL_W_DEF     = 8;
    localparam int unsigned PHASE_W       = 3;
    localparam int unsigned IDX_W         = 5;
    localparam int unsigned MASK_W        = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE      = 3'd0,
        PH_INT_ROW   = 3'd1,
        PH_INT_COL   = 3'd2,
        PH_WAIT_HALF = 3'd3,
        PH_HALF_A    = 3'd4,
        PH_HALF_B    = 3'd5,
        PH_HALF_C    = 3'd6,
        PH_DRAIN     = 3'd7
    } phase_e;

    // Tag carried on s: which phase issued the row and its index within that phase
    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic [IDX_W-1:0]   index;
    } tag_t;

    // Sel boundaries as a function of block width
    function automatic int unsigned int_rows_of(input int unsigned np);
        return np + 7;
    endfunction

    function automatic int unsigned int_cols_of(input int unsigned np);
        return int_rows_of(np) + 8;
    endfunction

    function automatic int unsigned ha_end_of(input int unsigned np);
        return int_cols_of(np) + np;
    endfunction

    function automatic int unsigned hb_end_of(input int unsigned np);
        return ha_end_of(np) + np;
    endfunction

    function automatic int unsigned hc_end_of(input int unsigned np);
        return hb_end_of(np) + np;
    endfunction

    localparam int unsigned INT_ROWS = int_rows_of(NUM_PIXEL_DEF);
    localparam int unsigned INT_COLS = int_cols_of(NUM_PIXEL_DEF);
    localparam int unsigned HA_END   = ha_end_of(NUM_PIXEL_DEF);
    localparam int unsigned HB_END   = hb_end_of(NUM_PIXEL_DEF);
    localparam int unsigned HC_END   = hc_end_of(NUM_PIXEL_DEF);

    // Phase that follows cur once its work is finished, skipping masked half phases
    function automatic phase_e next_phase(input phase_e cur, input logic [MASK_W-1:0] mask);
        phase_e nxt;
        nxt = PH_DRAIN;
        case (cur)
            PH_IDLE:      nxt = PH_INT_ROW;
            PH_INT_ROW:   nxt = PH_INT_COL;
            PH_INT_COL:   nxt = (mask == '0) ? PH_DRAIN : PH_WAIT_HALF;
            PH_WAIT_HALF: nxt = mask[0] ? PH_HALF_A : (mask[1] ? PH_HALF_B : PH_HALF_C);
            PH_HALF_A:    nxt = mask[1] ? PH_HALF_B : (mask[2] ? PH_HALF_C : PH_DRAIN);
            PH_HALF_B:    nxt = mask[2] ? PH_HALF_C : PH_DRAIN;
            default:      nxt = PH_DRAIN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/interp_issue_pipe.sv
// interp_issue_pipe: delays the issue strobe and last-row flag so data_valid and done
// line up with the registered output of input_array_mux.
module interp_issue_pipe (
    input  logic clock,
    input  logic reset,
    input  logic issue_in,
    input  logic last_in,
    output logic data_valid,
    output logic done
);

    logic issue_q;
    logic last_q;
    logic valid_q;
    logic done_q;

    // Stage 1 tracks the sel/s register, stage 2 tracks the mux output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            issue_q <= issue_in;
            last_q  <= last_in;
            valid_q <= issue_q;
            done_q  <= issue_q & last_q;
        end
    end

    assign data_valid = valid_q;
    assign done       = done_q;

endmodule

// File: rtl/interp_sel_sequencer.sv
// interp_sel_sequencer: walks input_array_mux through one 8x8 interpolation pass
// (integer rows, integer columns, half-pel A/B/C rows), stalling on dst_ready and
// waiting for half_ready before the half-pel phases.
// Optional build macro INTERP_SEL_FRAC_MASK_EN adds frac_mask[2:0] to skip half phases.
module interp_sel_sequencer
    import interp_pkg::*;
#(
    parameter int unsigned NUM_PIXEL = NUM_PIXEL_DEF,
    parameter int unsigned SEL_W     = SEL_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               dst_ready,
    input  logic               half_ready,
`ifdef INTERP_SEL_FRAC_MASK_EN
    input  logic [MASK_W-1:0]  frac_mask,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic [SEL_W-1:0]   s,
    output logic               data_valid,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] phase
);

    localparam int unsigned INT_ROWS_L = int_rows_of(NUM_PIXEL);
    localparam int unsigned INT_COLS_L = int_cols_of(NUM_PIXEL);
    localparam int unsigned HA_END_L   = ha_end_of(NUM_PIXEL);
    localparam int unsigned HB_END_L   = hb_end_of(NUM_PIXEL);
    localparam int unsigned HC_END_L   = hc_end_of(NUM_PIXEL);

    phase_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    s_q, s_d;
    logic                busy_q, busy_d;
    logic                drain_q, drain_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                issue_d;
    logic                last_d;

    logic                issuing;
    int unsigned         base_v;
    int unsigned         last_idx_v;
    tag_t                tag;

    // Next-state, counter and issue decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        s_d        = s_q;
        drain_d    = drain_q;
        mask_d     = mask_q;
        issue_d    = 1'b0;
        last_d     = 1'b0;
        issuing    = 1'b0;
        base_v     = 0;
        last_idx_v = 0;
        tag        = '0;

        case (state_q)
            PH_IDLE: begin
                if (start) begin
                    state_d = PH_INT_ROW;
                    idx_d   = '0;
                    drain_d = 1'b0;
`ifdef INTERP_SEL_FRAC_MASK_EN
                    mask_d  = frac_mask;
`else
                    mask_d  = '1;
`endif
                end
            end
            PH_INT_ROW: begin
                issuing    = 1'b1;
                base_v     = 0;
                last_idx_v = INT_ROWS_L - 1;
            end
            PH_INT_COL: begin
                issuing    = 1'b1;
                base_v     = INT_ROWS_L;
                last_idx_v = INT_COLS_L - INT_ROWS_L - 1;
            end
            PH_WAIT_HALF: begin
                if (half_ready) begin
                    state_d = next_phase(state_q, mask_q);
                end
            end
            PH_HALF_A: begin
                issuing    = 1'b1;
                base_v     = INT_COLS_L;
                last_idx_v = HA_END_L - INT_COLS_L - 1;
            end
            PH_HALF_B: begin
                issuing    = 1'b1;
                base_v     = HA_END_L;
                last_idx_v = HB_END_L - HA_END_L - 1;
            end
            PH_HALF_C: begin
                issuing    = 1'b1;
                base_v     = HB_END_L;
                last_idx_v = HC_END_L - HB_END_L - 1;
            end
            PH_DRAIN: begin
                // Two cycles let the last row reach data_valid/done, then release busy
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = PH_IDLE;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase

        if (issuing && dst_ready) begin
            tag.phase = state_q;
            tag.index = idx_q;
            sel_d     = SEL_W'(base_v + 32'(idx_q));
            s_d       = SEL_W'(tag);
            issue_d   = 1'b1;
            if (idx_q == IDX_W'(last_idx_v)) begin
                idx_d   = '0;
                state_d = next_phase(state_q, mask_q);
                last_d  = (state_d == PH_DRAIN);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        busy_d = (state_d != PH_IDLE);
    end

    // State, counter and registered mux drive
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= PH_IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            drain_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            drain_q <= drain_d;
            mask_q  <= mask_d;
        end
    end

    interp_issue_pipe u_issue_pipe (
        .clock      (clock),
        .reset      (reset),
        .issue_in   (issue_d),
        .last_in    (last_d),
        .data_valid (data_valid),
        .done       (done)
    );

    assign sel   = sel_q;
    assign s     = s_q;
    assign busy  = busy_q;
    assign phase = state_q;

endmodule

// File: tb/tb_interp_sel_sequencer.sv
// Bench for interp_sel_sequencer: expected issue order built from the sel ranges,
// checked pulse by pulse by a monitor, plus directed stall/wait/start/reset cases.
module tb_interp_sel_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       dst_ready;
    logic       half_ready;
`ifdef INTERP_SEL_FRAC_MASK_EN
    logic [2:0] frac_mask;
`endif
    logic [7:0] sel;
    logic [7:0] s;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    interp_sel_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dst_ready  (dst_ready),
        .half_ready (half_ready),
`ifdef INTERP_SEL_FRAC_MASK_EN
        .frac_mask  (frac_mask),
`endif
        .sel        (sel),
        .s          (s),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done),
        .phase      (phase)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: phase code and index of a sel value from the documented ranges
    function automatic int tag_of(input int v);
        int ph;
        int b;
        if (v < 15)      begin ph = 1; b = 0;  end
        else if (v < 23) begin ph = 2; b = 15; end
        else if (v < 31) begin ph = 4; b = 23; end
        else if (v < 39) begin ph = 5; b = 31; end
        else             begin ph = 6; b = 39; end
        return ph * 32 + (v - b);
    endfunction

    int         exp_q[$];
    int         pass_len;
    int         pulses;
    int         e;
    bit         mon_en;
    bit         saw_wait;
    logic [2:0] cur_mask;
    logic [7:0] prev_sel;
    logic [7:0] prev_s;
    bit         rand_en;
    int         rdy_pct;

    // Monitor: each data_valid must present the row issued on the previous cycle
    always @(negedge clock) begin
        if (mon_en) begin
            if (phase == 3'd3) saw_wait = 1'b1;
            if (data_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("valid_count_overrun", pulses, pass_len);
                end else begin
                    e = exp_q.pop_front();
                    chk("issued_sel", int'(prev_sel), e);
                    chk("issued_tag", int'(prev_s), tag_of(e));
                    chk("done_align", int'(done), int'(exp_q.size() == 0));
                end
            end
            if (done) chk("done_needs_valid", int'(data_valid), 1);
        end
        prev_sel = sel;
        prev_s   = s;
    end

    // Random backpressure and half-array readiness
    always @(negedge clock) begin
        if (rand_en) begin
            dst_ready  = ($urandom_range(99) < rdy_pct);
            half_ready = ($urandom_range(3) != 0);
        end
    end

    task automatic begin_pass(input logic [2:0] m);
        exp_q.delete();
        for (int v = 0; v < 23; v++) exp_q.push_back(v);
        if (m[0]) for (int v = 23; v < 31; v++) exp_q.push_back(v);
        if (m[1]) for (int v = 31; v < 39; v++) exp_q.push_back(v);
        if (m[2]) for (int v = 39; v < 47; v++) exp_q.push_back(v);
        pass_len = exp_q.size();
        pulses   = 0;
        saw_wait = 1'b0;
        cur_mask = m;
`ifdef INTERP_SEL_FRAC_MASK_EN
        frac_mask = m;
`endif
        mon_en = 1'b1;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic end_pass();
        wait_done();
        @(negedge clock);
        chk("pulse_count", pulses, pass_len);
        chk("busy_clear", int'(busy), 0);
        chk("phase_idle", int'(phase), 0);
        chk("wait_half_entered", int'(saw_wait), int'(cur_mask != 3'b000));
        mon_en = 1'b0;
    endtask

    task automatic wait_sel(input int v);
        int n;
        n = 0;
        while (int'(sel) != v && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("reached_sel", int'(sel), v);
    endtask

    typedef struct {
        int         rdy_pct;
        logic [2:0] mask;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int t46;
        int td;
        int cyc;
        vec_t v;

        vecs.push_back('{100, 3'b111, 47});
        vecs.push_back('{50,  3'b111, 47});
        vecs.push_back('{25,  3'b111, 47});
        vecs.push_back('{85,  3'b111, 47});
`ifdef INTERP_SEL_FRAC_MASK_EN
        vecs.push_back('{100, 3'b010, 31});
        vecs.push_back('{100, 3'b000, 23});
        vecs.push_back('{60,  3'b101, 39});
        vecs.push_back('{60,  3'b100, 31});
        vecs.push_back('{40,  3'b000, 23});
`endif

        reset = 1'b1; start = 1'b0; dst_ready = 1'b0; half_ready = 1'b0;
        rand_en = 1'b0; mon_en = 1'b0; rdy_pct = 100;
`ifdef INTERP_SEL_FRAC_MASK_EN
        frac_mask = 3'b111;
`endif
        repeat (2) @(negedge clock);
        chk("rst_sel", int'(sel), 0);
        chk("rst_s", int'(s), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_phase", int'(phase), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", int'(busy), 0);

        // Full-rate pass: done one cycle after sel=46 appears on sel
        dst_ready = 1'b1; half_ready = 1'b1;
        begin_pass(3'b111);
        t46 = -1; td = -1; cyc = 0;
        while (td < 0 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (int'(sel) == 46 && t46 < 0) t46 = cyc;
            if (done) td = cyc;
        end
        chk("done_latency", td - t46, 1);
        end_pass();

        // Stall at sel=5: sel holds, valid goes quiet after the in-flight row
        begin_pass(3'b111);
        wait_sel(5);
        dst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_sel_hold", int'(sel), 5);
            if (i >= 1) chk("stall_no_valid", int'(data_valid), 0);
        end
        dst_ready = 1'b1;
        end_pass();

        // half_ready low after sel=22: hold in WAIT_HALF, then sel=23 follows
        begin_pass(3'b111);
        wait_sel(22);
        half_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("wait_half_phase", int'(phase), 3);
            chk("wait_half_sel", int'(sel), 22);
        end
        half_ready = 1'b1;
        @(negedge clock);
        chk("half_a_phase", int'(phase), 4);
        @(negedge clock);
        chk("half_a_first_sel", int'(sel), 23);
        end_pass();

        // start while busy and start coincident with done are both ignored
        begin_pass(3'b111);
        wait_sel(30);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_start_pulses", pulses, 47);
        chk("start_at_done_busy", int'(busy), 0);
        chk("start_at_done_phase", int'(phase), 0);
        mon_en = 1'b0;
        begin_pass(3'b111);
        end_pass();

        // Asynchronous reset mid-pass
        rdy_pct = 70; rand_en = 1'b1;
        begin_pass(3'b111);
        wait_sel(35);
        reset = 1'b1;
        #1;
        chk("async_sel", int'(sel), 0);
        chk("async_s", int'(s), 0);
        chk("async_valid", int'(data_valid), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_phase", int'(phase), 0);
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("reset_hold_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clock);

        // Table of backpressure levels and masks
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rdy_pct = v.rdy_pct;
            begin_pass(v.mask);
            end_pass();
            chk("table_pulses", pulses, v.exp_pulses);
        end

        // Random backpressure passes
        for (int i = 0; i < 4; i++) begin
            rdy_pct = int'($urandom_range(100, 15));
            begin_pass(3'b111);
            end_pass();
        end
        rand_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
